// File: rtl/mfcc_frame_buf.sv
// Pre-emphasis + circular sample buffer + overlapping framer feeding the FFT input stream.
// Latency: FRAME_LEN-th sample accepted at edge N -> word 0 valid after edge N+2; back-to-back words within a frame.
// Backpressure: pcm_ready low once 2^BUF_AW samples are held (drops flagged on overrun); ready_in low freezes the output.
//
// Ports:
//   hclk, rst        clock (rising edge), asynchronous active-high reset
//   clr              synchronous flush of pointers, x_prev, FSM and output stage
//   pcm_in/valid     signed 16-bit sample in; pcm_ready = buffer has room
//   overrun          registered one-cycle pulse per dropped sample
//   data_out/valid_out/ready_in/last  32-bit sign-extended frame words out, last on word FRAME_LEN-1
//   frame_cnt        frames fully emitted since reset/clr (wraps)
module mfcc_frame_buf #(
  parameter int FRAME_LEN = 256,
  parameter int HOP       = 128,
  parameter int BUF_AW    = 9,
  parameter int PRE_SHIFT = 5
) (
  input  logic               hclk,
  input  logic               rst,
  input  logic               clr,
  input  logic signed [15:0] pcm_in,
  input  logic               pcm_valid,
  output logic               pcm_ready,
  output logic               overrun,
  output logic [31:0]        data_out,
  output logic               valid_out,
  input  logic               ready_in,
  output logic               last,
  output logic [15:0]        frame_cnt
);

  localparam int DEPTH = 1 << BUF_AW;
  localparam int KW    = $clog2(FRAME_LEN) + 1;

  localparam logic [BUF_AW:0] FRAME_LEN_P = (BUF_AW+1)'(FRAME_LEN);
  localparam logic [BUF_AW:0] HOP_P       = (BUF_AW+1)'(HOP);
  localparam logic [BUF_AW:0] DEPTH_P     = (BUF_AW+1)'(DEPTH);
  localparam logic [BUF_AW:0] PTR_ONE     = (BUF_AW+1)'(1);
  localparam logic [KW-1:0]   K_LAST      = KW'(FRAME_LEN - 1);
  localparam logic [KW-1:0]   K_END       = KW'(FRAME_LEN);
  localparam logic [KW-1:0]   K_ONE       = KW'(1);

  // ---------------------------------------------------------------- input side
  logic [BUF_AW:0]    wr_ptr;
  logic [BUF_AW:0]    base;
  logic [BUF_AW:0]    occ;
  logic signed [15:0] x_prev;
  logic signed [16:0] x_ext;
  logic signed [16:0] p_ext;
  logic signed [16:0] emph;
  logic               accept;

  // Pointers carry one extra bit so a completely full buffer (occ == DEPTH) is distinguishable from empty.
  assign occ       = wr_ptr - base;
  assign pcm_ready = (occ < DEPTH_P);
  assign accept    = pcm_valid & pcm_ready;

  // e = x - x_prev + floor(x_prev / 2^PRE_SHIFT); always fits 17 bits signed.
  always_comb begin
    x_ext = {pcm_in[15], pcm_in};
    p_ext = {x_prev[15], x_prev};
    emph  = x_ext - p_ext + (p_ext >>> PRE_SHIFT);
  end

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      x_prev  <= '0;
      overrun <= 1'b0;
    end else if (clr) begin
      wr_ptr  <= '0;
      x_prev  <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= pcm_valid & ~pcm_ready;
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        x_prev <= pcm_in;
      end
    end
  end

  // ---------------------------------------------------------------- sample RAM
  logic [16:0]       mem [DEPTH];
  logic [16:0]       ram_q;
  logic [BUF_AW-1:0] rd_addr;
  logic              issue;
  logic [KW-1:0]     fetch_k;

  assign rd_addr = base[BUF_AW-1:0] + BUF_AW'(fetch_k);

  always_ff @(posedge hclk) begin
    if (accept && !clr) mem[wr_ptr[BUF_AW-1:0]] <= emph;
    if (issue)          ram_q <= mem[rd_addr];
  end

  // ---------------------------------------------------------------- framer FSM + output skid
  typedef enum logic {S_WAIT, S_SEND} state_t;

  state_t      state;
  logic        q_vld;      // ram_q holds a fetched word this cycle
  logic        q_last;
  logic [16:0] out_dat;
  logic        out_vld;
  logic        out_last;
  logic [16:0] sk_dat;
  logic        sk_vld;
  logic        sk_last;
  logic        pop;
  logic        head_free;
  logic [1:0]  fill;

  assign pop       = out_vld & ready_in;
  assign head_free = ~out_vld | ready_in;

  // Words held or in flight after this edge must not exceed two, since a fetched word
  // always lands next cycle. Limiting the pre-issue count to one still allows one
  // fetch per cycle while the consumer pops every cycle.
  always_comb begin
    fill  = 2'(out_vld) + 2'(sk_vld) + 2'(q_vld) - 2'(pop);
    issue = 1'b0;
    if (fill <= 2'd1) begin
      if (state == S_WAIT) issue = (occ >= FRAME_LEN_P);
      else                 issue = (fetch_k != K_END);
    end
  end

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      state     <= S_WAIT;
      fetch_k   <= '0;
      base      <= '0;
      frame_cnt <= '0;
      q_vld     <= 1'b0;
      q_last    <= 1'b0;
      out_dat   <= '0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      sk_dat    <= '0;
      sk_vld    <= 1'b0;
      sk_last   <= 1'b0;
    end else if (clr) begin
      state     <= S_WAIT;
      fetch_k   <= '0;
      base      <= '0;
      frame_cnt <= '0;
      q_vld     <= 1'b0;
      q_last    <= 1'b0;
      out_dat   <= '0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      sk_dat    <= '0;
      sk_vld    <= 1'b0;
      sk_last   <= 1'b0;
    end else begin
      // Word 0 is fetched on the same edge that leaves WAIT to save a cycle of latency.
      q_vld <= issue;
      if (issue) begin
        q_last  <= (fetch_k == K_LAST);
        fetch_k <= fetch_k + K_ONE;
        state   <= S_SEND;
      end

      if (head_free) begin
        if (sk_vld) begin
          out_dat  <= sk_dat;
          out_last <= sk_last;
          out_vld  <= 1'b1;
          sk_dat   <= ram_q;
          sk_last  <= q_last;
          sk_vld   <= q_vld;
        end else begin
          out_vld  <= q_vld;
          out_last <= q_vld & q_last;
          if (q_vld) out_dat <= ram_q;
        end
      end else if (q_vld) begin
        sk_dat  <= ram_q;
        sk_last <= q_last;
        sk_vld  <= 1'b1;
      end

      // Final word leaves: all fetches are done, so the pipeline is empty behind it.
      if (pop && out_last) begin
        base      <= base + HOP_P;
        frame_cnt <= frame_cnt + 16'd1;
        fetch_k   <= '0;
        state     <= S_WAIT;
      end
    end
  end

  assign data_out  = {{15{out_dat[16]}}, out_dat};
  assign valid_out = out_vld;
  assign last      = out_last;

endmodule

// File: tb/tb_mfcc_frame_buf.sv
module tb_mfcc_frame_buf;

  localparam int FL   = 256;
  localparam int HOPN = 128;

  logic               hclk = 1'b0;
  logic               rst = 1'b1;
  logic               clr = 1'b0;
  logic signed [15:0] pcm_in = '0;
  logic               pcm_valid = 1'b0;
  logic               pcm_ready;
  logic               overrun;
  logic [31:0]        data_out;
  logic               valid_out;
  logic               ready_in = 1'b0;
  logic               last;
  logic [15:0]        frame_cnt;

  mfcc_frame_buf #(.FRAME_LEN(256), .HOP(128), .BUF_AW(9), .PRE_SHIFT(5)) dut (
    .hclk(hclk), .rst(rst), .clr(clr),
    .pcm_in(pcm_in), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .overrun(overrun),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in), .last(last),
    .frame_cnt(frame_cnt)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovr_cnt = 0;

  logic [31:0] got_dat[$];
  logic        got_last[$];
  int          got_cyc[$];
  int          stim[$];
  int          acc[$];

  always @(posedge hclk) cyc++;

  // Transfers and overrun pulses observed mid-cycle, where everything is stable.
  always @(negedge hclk) begin
    if (!rst && !clr && valid_out && ready_in) begin
      got_dat.push_back(data_out);
      got_last.push_back(last);
      got_cyc.push_back(cyc);
    end
    if (!rst && !clr && overrun) ovr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic clear_logs();
    got_dat.delete();
    got_last.delete();
    got_cyc.delete();
    acc.delete();
    ovr_cnt = 0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    clear_logs();
  endtask

  function automatic int pe(input int x, input int xp);
    return x - xp + (xp >>> 5);
  endfunction

  // Offers stim[] in order, holding each sample until accepted.
  task automatic feed();
    int i;
    int budget;
    i = 0;
    budget = 4 * stim.size() + 2000;
    while (i < stim.size() && budget > 0) begin
      pcm_in = 16'(stim[i]);
      pcm_valid = 1'b1;
      @(negedge hclk);
      if (pcm_ready) begin
        acc.push_back(stim[i]);
        i++;
      end
      tick();
      budget--;
    end
    pcm_valid = 1'b0;
    chk("feed_done", i, stim.size());
  endtask

  task automatic wait_frames(input int n, input string name);
    int b;
    b = 0;
    while (frame_cnt != 16'(n) && b < 4000) begin
      tick();
      b++;
    end
    chk(name, frame_cnt, n);
  endtask

  // Compares collected words with frames cut from the reference pre-emphasized stream.
  task automatic check_frames(input int nf, input string name);
    int e_ref[$];
    int xp;
    int bad;
    int bad_idx;
    logic [31:0] bad_act;
    logic [31:0] bad_exp;
    xp = 0;
    foreach (acc[i]) begin
      e_ref.push_back(pe(acc[i], xp));
      xp = acc[i];
    end
    chk({name, "_count"}, got_dat.size(), nf * FL);
    bad = 0;
    bad_idx = 0;
    bad_act = '0;
    bad_exp = '0;
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < FL; k++) begin
        int idx;
        int ridx;
        logic [31:0] ev;
        idx = f * FL + k;
        ridx = f * HOPN + k;
        ev = (ridx < e_ref.size()) ? 32'(e_ref[ridx]) : 32'hDEADBEEF;
        if (idx < got_dat.size()) begin
          if (got_dat[idx] !== ev || got_last[idx] !== (k == FL - 1)) begin
            if (bad == 0) begin
              bad_idx = idx;
              bad_act = got_dat[idx];
              bad_exp = ev;
            end
            bad++;
          end
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_words first bad word %0d actual=%h expected=%h (%0d bad words/last flags)",
               name, bad_idx, bad_act, bad_exp, bad);
    end
  endtask

  typedef struct {
    int          x_even;
    int          x_odd;
    logic [31:0] e0;
    logic [31:0] e_odd;
    logic [31:0] e_even;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bad;
    int first_drop;
    int b;
    logic [31:0] ev;

    vecs[0] = '{1000,   1000,   32'd1000,     32'd31,       32'd31};
    vecs[1] = '{-1000,  -1000,  32'hFFFFFC18, 32'hFFFFFFE0, 32'hFFFFFFE0};
    vecs[2] = '{32767,  -32768, 32'd32767,    32'hFFFF0400, 32'd64511};
    vecs[3] = '{-1,     -1,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4] = '{31,     31,     32'd31,       32'd0,        32'd0};

    // ---- reset state
    tick();
    tick();
    chk("rst_pcm_ready", pcm_ready, 1);
    chk("rst_overrun", overrun, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_last", last, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid_out", valid_out, 0);

    // ---- table-driven single frames
    for (int v = 0; v < 5; v++) begin
      do_clr();
      ready_in = 1'b1;
      stim.delete();
      for (int k = 0; k < FL; k++) stim.push_back((k % 2 == 0) ? vecs[v].x_even : vecs[v].x_odd);
      feed();
      chk($sformatf("v%0d_lat_n", v), valid_out, 0);
      tick();
      chk($sformatf("v%0d_lat_n1", v), valid_out, 0);
      tick();
      chk($sformatf("v%0d_lat_n2", v), valid_out, 1);
      chk($sformatf("v%0d_word0", v), data_out, vecs[v].e0);
      wait_frames(1, $sformatf("v%0d_frame_cnt", v));
      chk($sformatf("v%0d_count", v), got_dat.size(), FL);
      bad = 0;
      for (int k = 0; k < FL; k++) begin
        ev = (k == 0) ? vecs[v].e0 : ((k % 2 == 1) ? vecs[v].e_odd : vecs[v].e_even);
        if (k < got_dat.size()) begin
          if (got_dat[k] !== ev || got_last[k] !== (k == FL - 1)) bad++;
        end
      end
      chk($sformatf("v%0d_words_bad", v), bad, 0);
      tick();
      tick();
      chk($sformatf("v%0d_idle", v), valid_out, 0);
    end

    // ---- ramp 0..639: four overlapping frames, buffer wrap, gaps
    do_clr();
    ready_in = 1'b1;
    stim.delete();
    for (int i = 0; i < 640; i++) stim.push_back(i);
    feed();
    wait_frames(4, "ramp_frame_cnt");
    check_frames(4, "ramp");
    if (got_dat.size() == 4 * FL) begin
      chk("ramp_f1_word0", got_dat[FL], 32'd4);
      chk("ramp_f3_word255", got_dat[4 * FL - 1], 32'd20);
      bad = 0;
      for (int i = 1; i < 4 * FL; i++) begin
        if (i % FL == 0) begin
          if (got_cyc[i] - got_cyc[i - 1] > 3) bad++;
        end else if (got_cyc[i] - got_cyc[i - 1] != 1) begin
          bad++;
        end
      end
      chk("ramp_gaps", bad, 0);
    end
    tick();
    tick();
    tick();
    chk("ramp_idle", valid_out, 0);

    // ---- downstream stalled while 1000 samples are offered
    do_clr();
    ready_in = 1'b0;
    first_drop = -1;
    for (int i = 0; i < 1000; i++) begin
      int xv;
      xv = (i * 37) % 2001 - 1000;
      pcm_in = 16'(xv);
      pcm_valid = 1'b1;
      @(negedge hclk);
      if (pcm_ready) acc.push_back(xv);
      else if (first_drop < 0) first_drop = i;
      if (i == 300) begin
        chk("bp_valid_mid", valid_out, 1);
        chk("bp_word0_mid", data_out, 32'hFFFFFC18);
      end
      tick();
    end
    pcm_valid = 1'b0;
    chk("bp_accepted", acc.size(), 512);
    chk("bp_first_drop", first_drop, 512);
    chk("bp_pcm_ready_low", pcm_ready, 0);
    chk("bp_word0_end", data_out, 32'hFFFFFC18);
    chk("bp_last_end", last, 0);
    tick();
    tick();
    chk("bp_overrun_pulses", ovr_cnt, 488);
    chk("bp_overrun_quiet", overrun, 0);
    chk("bp_no_transfer", got_dat.size(), 0);
    ready_in = 1'b1;
    wait_frames(3, "bp_frame_cnt");
    check_frames(3, "bp");
    chk("bp_pcm_ready_back", pcm_ready, 1);

    // ---- clr in the middle of the second frame
    do_clr();
    ready_in = 1'b1;
    stim.delete();
    for (int i = 0; i < 512; i++) stim.push_back(2000 + i);
    feed();
    b = 0;
    while (got_dat.size() < FL + 100 && b < 2000) begin
      tick();
      b++;
    end
    chk("clr_reach_word100", got_dat.size(), FL + 100);
    chk("clr_pre_frame_cnt", frame_cnt, 1);
    chk("clr_pre_valid", valid_out, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_valid_out", valid_out, 0);
    chk("clr_frame_cnt", frame_cnt, 0);
    chk("clr_last", last, 0);
    chk("clr_pcm_ready", pcm_ready, 1);
    clear_logs();
    stim.delete();
    for (int i = 0; i < FL - 1; i++) stim.push_back(500);
    feed();
    tick();
    tick();
    tick();
    chk("clr_no_early_frame", valid_out, 0);
    stim.delete();
    stim.push_back(500);
    feed();
    tick();
    chk("clr_lat_n1", valid_out, 0);
    tick();
    chk("clr_lat_n2", valid_out, 1);
    chk("clr_word0_raw", data_out, 32'd500);
    wait_frames(1, "clr_new_frame_cnt");
    if (got_dat.size() > 1) chk("clr_word1", got_dat[1], 32'd15);
    check_frames(1, "clr_new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mfcc_frame_buf.md
# mfcc_frame_buf

Pre-emphasis and framing stage directly upstream of the windowed FFT in the MFCC accelerator. It accepts a continuous 16-bit PCM sample stream, applies first-order pre-emphasis, and stores results in a circular buffer. It emits overlapping frames of FRAME_LEN samples, advancing by HOP samples per frame, as 32-bit sign-extended words on a valid/ready stream. That stream connects straight to the FFT data/valid/ready input.

## Interface
- FRAME_LEN, 256: samples per output frame (power of two, ≤ 2^BUF_AW − HOP)
- HOP, 128: frame advance in samples (1..FRAME_LEN)
- BUF_AW, 9: buffer address width; depth 2^BUF_AW words of 17 bits
- PRE_SHIFT, 5: pre-emphasis coefficient α = 1 − 2^−PRE_SHIFT
- hclk  in  1  sole clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous flush: pointers, x_prev, output stage cleared; same values as reset
- pcm_in  in  16  signed PCM sample
- pcm_valid  in  1  sample present
- pcm_ready  out  1  buffer can accept a sample
- overrun  out  1  one-cycle pulse: pcm_valid high while pcm_ready low (sample dropped)
- data_out  out  32  pre-emphasized sample, 17-bit signed sign-extended to 32
- valid_out  out  1  data_out valid
- ready_in  in  1  downstream (FFT) accepts
- last  out  1  high with final word (index FRAME_LEN−1) of each frame
- frame_cnt  out  16  frames fully emitted since reset/clr, wraps at 65535→0

## Operation
- Pre-emphasis on accept (pcm_valid & pcm_ready): e = x − x_prev + (x_prev >>> PRE_SHIFT), arithmetic shift (floor). 17-bit signed, no saturation needed (range −64512..64511 for PRE_SHIFT=5). x_prev ← x after each accept. x_prev = 0 after reset/clr.
- Written to buf[wr_ptr]; wr_ptr (BUF_AW+1 bits) increments. Dropped samples do not update x_prev or wr_ptr.
- base (BUF_AW+1 bits) = index of first sample of current frame; occ = wr_ptr − base (modulo 2^(BUF_AW+1)).
- pcm_ready = (occ < 2^BUF_AW). Combinational from registers, not from pcm_valid.
- FSM:
  - WAIT: occ ≥ FRAME_LEN → SEND, k = 0.
  - SEND: read buf[base+k] (address modulo depth), present in order. Each accepted word (valid_out & ready_in): k++. On the word with k = FRAME_LEN−1 accepted: base += HOP, frame_cnt++, → WAIT.
- Writes continue during SEND. Write and read addresses never collide within an active frame because occ ≤ depth.
- Simultaneous accept and frame completion in one cycle: both take effect; occ updates by +1 −HOP.
- Reset/clr mid-frame: frame abandoned, valid_out/last drop next edge (reset: immediately), buffer contents don't-care.

## Timing
- Reset values: pcm_ready 1, overrun 0, valid_out 0, last 0, data_out 0, frame_cnt 0, FSM WAIT.
- Buffer is synchronous-read RAM (1-cycle). Output stage is a 2-entry skid/prefetch so that valid_out can stay high every cycle while ready_in is high. No bubbles within a frame when ready_in is held high.
- Latency: FRAME_LEN-th sample accepted at edge N → valid_out high after edge N+2, with word 0.
- When valid_out is high and ready_in is low, data_out, last, and valid_out stay stable until accepted (AXI-style). valid_out never drops mid-frame except on reset/clr.
- With HOP < FRAME_LEN and occ already ≥ FRAME_LEN after completion, next frame starts with ≤ 2 idle cycles between last and the next word 0.
- overrun is registered: asserted the cycle after the dropped beat.

## Test plan
- Constant x = 1000, 256 samples, ready_in = 1 → word0 = 1000, words 1..255 = 31. last on word 255, frame_cnt = 1, valid_out at +2 cycles after sample 256.
- Constant x = −1000 → word0 = −1000 (0xFFFFFC18), then −32 (0xFFFFFFE0) each; checks floor shift and sign extension.
- Extremes: alternate 32767/−32768 → outputs 64511 / −64512 exact; no wrap.
- Ramp 0..639 continuous, ready_in = 1 → frames start at sample indices 0, 128, 256, 384; overlap content matches a reference model. frame_cnt = 4 after 640 samples; buffer address wraps at 512 cleanly.
- ready_in held 0 after frame start while 1000 samples offered → pcm_ready drops when occ = 512. overrun pulses once per dropped beat; data_out word0 held stable; release gives correct frame.
- clr asserted at word 100 of frame 2 → valid_out 0 next cycle, frame_cnt 0. Next output appears only after 256 new samples, word0 = raw x (x_prev reset).
